attractor_logger: RTL and testbench

ATTRACTOR_LOGGER -- requirements
Module: attractor_logger

---
 rtl/gene_net_pkg.sv | 33 +++
 rtl/attractor_logger_result_ram.sv | 47 ++++
 rtl/attractor_logger.sv | 167 ++++++++++++++++
 tb/tb_attractor_logger.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gene_net_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gene_net_pkg
// Description : Shared encodings for the attractor logger: result types,
//               FSM state type, widths and a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gene_net_pkg;

    // Width of a gene network state / initial value
    localparam int STATE_W = 8;
    // Width of the event counters
    localparam int CNT_W   = 9;

    // Result type encodings stored with each logged entry
    localparam logic [1:0] TYPE_NONE    = 2'b00;
    localparam logic [1:0] TYPE_FIXED   = 2'b01;
    localparam logic [1:0] TYPE_CYCLE   = 2'b10;
    localparam logic [1:0] TYPE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOG   = 2'd2
    } state_e;

    // Event counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/attractor_logger_result_ram.sv
`default_nettype none
// ============================================================================
// Module      : result_ram
// Description : 256 x 16 result storage ({steps, attractor_x}), one write
//               port and one registered read port. Read-before-write when
//               both ports hit the same address in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module result_ram
    import gene_net_pkg::*;
#(
    parameter int ADDR_W = STATE_W,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Write port; the array itself is never reset (valid bits live upstream)
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; sees the array contents from before this edge's write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/attractor_logger.sv
`default_nettype none
// ============================================================================
// Module      : attractor_logger
// Description : Tracks gene network trajectories started by a new initial
//               value, logs the attractor reached (fixed / cycle / timeout)
//               into a result RAM indexed by the initial value, and serves
//               host reads with one cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module attractor_logger
    import gene_net_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] init_val_i,
    input  logic [STATE_W-1:0] x_i,
    input  logic               fixed_i,
    input  logic               cycle_i,
    input  logic               rd_en_i,
    input  logic [STATE_W-1:0] rd_addr_i,
    output logic [17:0]        rd_data_o,
    output logic               rd_valid_o,
    output logic [CNT_W-1:0]   fixed_cnt_o,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic               busy_o
);

    localparam logic [7:0] TIMEOUT_STEPS = 8'(TIMEOUT);

    state_e             state_q, state_d;
    logic [STATE_W-1:0] init_val_q;
    logic [7:0]         steps_q, steps_d;
    logic [1:0]         ent_type_q, ent_type_d;
    logic [7:0]         ent_steps_q, ent_steps_d;
    logic [STATE_W-1:0] ent_x_q, ent_x_d;
    logic [255:0]       valid_q;
    logic [1:0]         type_mem_q [256];
    logic [CNT_W-1:0]   fixed_cnt_q, cycle_cnt_q;
    logic               rd_valid_q, rd_hit_q;
    logic [1:0]         rd_type_q;
    logic [15:0]        ram_rdata;
    logic               log_we;
    logic               init_changed;

    assign init_changed = (init_val_i != init_val_q);
    assign log_we       = (state_q == ST_LOG);

    // Next-state logic: start, step counting, capture of the logged entry
    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        ent_type_d  = ent_type_q;
        ent_steps_d = ent_steps_q;
        ent_x_d     = ent_x_q;
        case (state_q)
            ST_IDLE: begin
                if (init_changed && (init_val_i != '0)) begin
                    state_d = ST_TRACK;
                    steps_d = '0;
                end
            end
            ST_TRACK: begin
                if (init_changed) begin
                    // Abandon the current trajectory; a new nonzero value restarts
                    steps_d = '0;
                    state_d = (init_val_i != '0) ? ST_TRACK : ST_IDLE;
                end else if (fixed_i || cycle_i || (steps_q == TIMEOUT_STEPS)) begin
                    state_d     = ST_LOG;
                    ent_steps_d = steps_q;
                    ent_x_d     = x_i;
                    ent_type_d  = fixed_i ? TYPE_FIXED :
                                  cycle_i ? TYPE_CYCLE : TYPE_TIMEOUT;
                end else if (steps_q != 8'hFF) begin
                    steps_d = steps_q + 1'b1;
                end
            end
            ST_LOG: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and trajectory registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            init_val_q  <= '0;
            steps_q     <= '0;
            ent_type_q  <= TYPE_NONE;
            ent_steps_q <= '0;
            ent_x_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_val_q  <= init_val_i;
            steps_q     <= steps_d;
            ent_type_q  <= ent_type_d;
            ent_steps_q <= ent_steps_d;
            ent_x_q     <= ent_x_d;
        end
    end

    // Valid bits and saturating event counters, updated in the LOG cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            fixed_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else if (log_we) begin
            valid_q[init_val_q] <= 1'b1;
            if (ent_type_q == TYPE_FIXED) begin
                fixed_cnt_q <= sat_inc(fixed_cnt_q);
            end
            if (ent_type_q == TYPE_CYCLE) begin
                cycle_cnt_q <= sat_inc(cycle_cnt_q);
            end
        end
    end

    // Type field storage kept next to the valid bits; not reset like the RAM
    always_ff @(posedge clk) begin
        if (log_we) begin
            type_mem_q[init_val_q] <= ent_type_q;
        end
    end

    // Read side: valid/type sampled alongside the RAM read (pre-write values)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_type_q  <= TYPE_NONE;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_hit_q  <= valid_q[rd_addr_i];
                rd_type_q <= type_mem_q[rd_addr_i];
            end
        end
    end

    result_ram #(
        .ADDR_W (STATE_W),
        .DATA_W (16)
    ) u_result_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (log_we),
        .waddr_i (init_val_q),
        .wdata_i ({ent_steps_q, ent_x_q}),
        .re_i    (rd_en_i),
        .raddr_i (rd_addr_i),
        .rdata_o (ram_rdata)
    );

    assign rd_data_o   = rd_hit_q ? {rd_type_q, ram_rdata} : 18'h0;
    assign rd_valid_o  = rd_valid_q;
    assign fixed_cnt_o = fixed_cnt_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_attractor_logger.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_attractor_logger
// Description : Randomized self-checking bench for attractor_logger against
//               a trajectory-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_attractor_logger;

    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  init_val, x, rd_addr;
    logic        fixed, cycle, rd_en;
    logic [17:0] rd_data;
    logic        rd_valid;
    logic [8:0]  fixed_cnt, cycle_cnt;
    logic        busy;

    always #5 clk = ~clk;

    attractor_logger #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_val_i  (init_val),
        .x_i         (x),
        .fixed_i     (fixed),
        .cycle_i     (cycle),
        .rd_en_i     (rd_en),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .fixed_cnt_o (fixed_cnt),
        .cycle_cnt_o (cycle_cnt),
        .busy_o      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: table of logged entries plus event counts
    bit          mdl_valid [256];
    logic [17:0] mdl_entry [256];
    int          mdl_fixed, mdl_cycle;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] mdl_read(input logic [7:0] a);
        return mdl_valid[a] ? mdl_entry[a] : 18'h0;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 256; i++) mdl_valid[i] = 1'b0;
        mdl_fixed = 0;
        mdl_cycle = 0;
    endtask

    // Entry point: just after a rising edge with the DUT idle or tracking.
    // kind: 0 none, 1 fixed, 2 cycle, 3 both; flag raised when step count == k.
    task automatic run_traj(input logic [7:0] a, input int k, input int kind,
                            input bit collide, input int xval);
        int          s;
        bit          hit;
        logic [1:0]  ty;
        logic [7:0]  st, xs;
        logic [17:0] old;
        init_val = a;
        @(posedge clk); #1;
        check_eq("busy_track", 32'(busy), 32'd1);
        s = 0;
        forever begin
            x     = (xval >= 0) ? 8'(xval) : 8'($urandom);
            hit   = (kind != 0) && (s == k);
            fixed = hit && (kind == 1 || kind == 3);
            cycle = hit && (kind == 2 || kind == 3);
            if (hit || s == TO) begin
                xs = x;
                st = 8'(s);
                ty = hit ? ((kind == 2) ? 2'b10 : 2'b01) : 2'b11;
                break;
            end
            @(posedge clk); #1;
            s++;
        end
        @(posedge clk); #1;
        fixed = 1'b0;
        cycle = 1'b0;
        x     = 8'($urandom);
        old   = mdl_read(a);
        if (collide) begin
            rd_en   = 1'b1;
            rd_addr = a;
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        if (collide) begin
            check_eq("collide_valid", 32'(rd_valid), 32'd1);
            check_eq("collide_data", 32'(rd_data), 32'(old));
        end
        mdl_valid[a] = 1'b1;
        mdl_entry[a] = {ty, st, xs};
        if (ty == 2'b01) mdl_fixed = (mdl_fixed >= 511) ? 511 : mdl_fixed + 1;
        if (ty == 2'b10) mdl_cycle = (mdl_cycle >= 511) ? 511 : mdl_cycle + 1;
        check_eq("busy_done", 32'(busy), 32'd0);
        check_eq("fixed_cnt", 32'(fixed_cnt), 32'(mdl_fixed));
        check_eq("cycle_cnt", 32'(cycle_cnt), 32'(mdl_cycle));
    endtask

    // Start a trajectory and let it run n steps without any flag
    task automatic partial_traj(input logic [7:0] a, input int n);
        init_val = a;
        @(posedge clk); #1;
        repeat (n) begin
            x = 8'($urandom);
            @(posedge clk); #1;
        end
        check_eq("busy_partial", 32'(busy), 32'd1);
    endtask

    // Read one address, then confirm rd_valid drops and rd_data holds
    task automatic do_read(input logic [7:0] a);
        logic [17:0] held;
        rd_en   = 1'b1;
        rd_addr = a;
        @(posedge clk); #1;
        rd_en   = 1'b0;
        rd_addr = 8'($urandom);
        check_eq("rd_valid", 32'(rd_valid), 32'd1);
        check_eq("rd_data", 32'(rd_data), 32'(mdl_read(a)));
        held = rd_data;
        @(posedge clk); #1;
        check_eq("rd_valid_idle", 32'(rd_valid), 32'd0);
        check_eq("rd_data_hold", 32'(rd_data), 32'(held));
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_fixed_cnt", 32'(fixed_cnt), 32'd0);
        check_eq("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] a;
        rst_n    = 1'b0;
        init_val = '0;
        x        = '0;
        fixed    = 1'b0;
        cycle    = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        mdl_clear();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios
        run_traj(8'h05, 3, 1, 1'b0, 8'h2A);
        do_read(8'h05);
        run_traj(8'h11, 7, 2, 1'b0, 8'h80);
        do_read(8'h11);
        run_traj(8'h33, 99, 0, 1'b0, -1);
        do_read(8'h33);
        run_traj(8'h40, 2, 3, 1'b0, -1);
        do_read(8'h40);
        run_traj(8'h41, TO, 2, 1'b0, -1);
        do_read(8'h41);
        partial_traj(8'h07, 3);
        run_traj(8'h08, 4, 1, 1'b0, -1);
        do_read(8'h07);
        do_read(8'h08);
        run_traj(8'h05, 1, 2, 1'b1, -1);
        do_read(8'h05);

        // Randomized trajectories
        for (int i = 0; i < 40; i++) begin
            do a = 8'($urandom_range(1, 255)); while (a == init_val);
            run_traj(a, int'($urandom_range(0, 13)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), -1);
            do_read(a);
            do_read(8'($urandom));
        end

        // Reset in the middle of a trajectory
        partial_traj(8'h99, 4);
        rst_n    = 1'b0;
        init_val = '0;
        #2;
        mdl_clear();
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(8'h05);
        do_read(8'h11);
        do_read(8'h99);
        run_traj(8'h22, 5, 1, 1'b0, -1);
        do_read(8'h22);

        // Drive the fixed counter into saturation
        for (int i = 0; i < 515; i++) begin
            run_traj((i % 2 == 0) ? 8'h01 : 8'h02, 0, 1, 1'b0, -1);
        end
        check_eq("fixed_sat", 32'(fixed_cnt), 32'd511);
        do_read(8'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
